gf_mult_arbiter: RTL
====================

// Module: gf_mult_arbiter
// PURPOSE
//  Shares one GF(2^163) interleaved multiplier among NUM_REQ requesters (point-add/double units).
//  Arbitrates round-robin, latches the winner's operands and sequences the multiplier's start/done protocol.
//  Returns the product tagged with the requester id.
//  Recovers a hung multiplier with a watchdog and a clear pulse.
// PARAMETERS
//  NUM_REQ     4    number of requesters, 2..8
//  M           163  field degree / operand width
//  TIMEOUT_CYC 200  WAIT cycles before abort; must exceed the multiplier worst case of 168
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, asynchronous, active-high
//  req        in   NUM_REQ    per-requester request level; held until its rsp_valid
//  opa        in   NUM_REQ*M  operand A, slice i belongs to requester i
//  opb        in   NUM_REQ*M  operand B, slice i belongs to requester i
//  grant      out  NUM_REQ    one-hot, 1-cycle pulse when operands are latched
//  rsp_valid  out  1          1-cycle result strobe
//  rsp_id     out  clog2(NUM_REQ)  requester owning rsp_data
//  rsp_data   out  M          product; 0 when rsp_err=1
//  rsp_err    out  1          watchdog abort flag, qualified by rsp_valid
//  busy       out  1          high in every state except IDLE
//  mult_a     out  M          multiplier operand A (registered)
//  mult_b     out  M          multiplier operand B (registered)
//  mult_start out  1          multiplier start (registered)
//  mult_clr   out  1          1-cycle pulse, ORed into the multiplier reset at top level
//  mult_done  in   1          multiplier done; mult_z valid only while high
//  mult_z     in   M          multiplier product
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, watchdog 0; asserting rst mid-operation abandons the operation, no rsp is issued.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; WAIT -> ABORT -> RESP on watchdog.
//  IDLE: if req!=0, pick the first set bit at or after the rr pointer (wrap NUM_REQ-1 -> 0).
//    Latch opa/opb slices into mult_a/mult_b and pulse grant[winner]; rr pointer <= winner+1 mod NUM_REQ; go to ISSUE.
//  ISSUE: mult_start<=1; clear watchdog; go to WAIT.
//  WAIT: mult_start stays 1 (the multiplier leaves SHIFT only if start is high); watchdog++.
//    On mult_done=1: capture mult_z into rsp_data, mult_start<=0 in the same edge, go to RESP.
//    If the watchdog reaches TIMEOUT_CYC-1 with no done: go to ABORT.
//  ABORT: mult_start<=0, mult_clr=1 for exactly 1 cycle, rsp_data<=0, rsp_err<=1; go to RESP.
//  RESP: rsp_valid=1, rsp_id=winner, 1 cycle; then IDLE.
//    rsp_err clears on the next grant.
//  Latency: grant to rsp_valid = multiplier latency + 3; the nominal multiplier is 166, so 169.
//  req dropped after grant: the operation completes and rsp is still issued.
//  A requester that still holds req in the cycle after rsp_valid is re-arbitrated as a new request.
//  mult_done outside WAIT is ignored.
//  mult_done and the watchdog limit in the same cycle: done wins, no abort.
//  mult_a/mult_b are stable from ISSUE until the return to IDLE; inputs opa/opb may change after grant.
//  rr pointer is unchanged by aborts except for the normal advance at grant.
// STRUCTURE
//  Package gf_mult_pkg: localparam M=163, state enum (IDLE, ISSUE, WAIT, ABORT, RESP), default TIMEOUT_CYC.
//  Sub-module rr_arbiter: NUM_REQ-wide, inputs req+ptr, outputs one-hot grant+index; combinational; pointer register lives in the parent.
//  Parent holds the FSM, operand/result registers and the watchdog counter (8 bits, sized from TIMEOUT_CYC).
// TESTING
//  Single: req=4'b0010, opa[1]=1, opb[1]=x^162.
//    -> grant=0010, rsp_id=1, rsp_data=x^162, rsp_err=0, 169 cycles after grant.
//  Reduction: opa=x^162, opb=x.
//    -> rsp_data=163'hC9 (x^7+x^6+x^3+1).
//  Fairness: req=4'b1111 held, re-raised after each rsp.
//    -> grant order 0,1,2,3,0; no requester granted twice before the others.
//  Hang: mult_done tied 0 with model frozen.
//    -> mult_clr pulse at WAIT cycle 200; rsp_valid with rsp_err=1, rsp_data=0; next request succeeds.
//  Reset mid-WAIT at cycle 50.
//    -> all outputs 0 immediately; no rsp_valid; a following req=0001 completes normally.
//  Collision: mult_done asserted on the same cycle the watchdog hits its limit (TIMEOUT_CYC=100 with a delayed-done model).
//    -> rsp_err=0, correct data, mult_clr never pulses.

Source files
------------

// File: rtl/gf_mult_pkg.sv
// Shared types and constants for the GF(2^163) multiplier arbiter.
package gf_mult_pkg;

    localparam int M = 163;
    localparam int TIMEOUT_CYC_DEFAULT = 200;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ABORT,
        RESP
    } state_t;

endpackage

// File: rtl/gf_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               valid
);

    logic [IDW:0] cand;

    // Scanning offsets from far to near lets the nearest candidate overwrite the others.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NUM_REQ)) begin
                cand = cand - (IDW + 1)'(NUM_REQ);
            end
            if (req[cand[IDW-1:0]]) begin
                idx   = cand[IDW-1:0];
                valid = 1'b1;
            end
        end
        grant = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Shares one GF(2^163) multiplier among NUM_REQ requesters with round-robin
// arbitration, start/done sequencing and a watchdog that clears a hung multiplier.
module gf_mult_arbiter
    import gf_mult_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int M           = gf_mult_pkg::M,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int WDW = $clog2(TIMEOUT_CYC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*M-1:0] opa,
    input  logic [NUM_REQ*M-1:0] opb,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [M-1:0]         rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [M-1:0]         mult_a,
    output logic [M-1:0]         mult_b,
    output logic                 mult_start,
    output logic                 mult_clr,
    input  logic                 mult_done,
    input  logic [M-1:0]         mult_z
);

    state_t              state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      owner;
    logic [WDW-1:0]      watchdog;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDW-1:0]      arb_idx;
    logic                arb_valid;
    logic [M-1:0]        sel_a;
    logic [M-1:0]        sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = opa[i*M +: M];
                sel_b = opb[i*M +: M];
            end
        end
    end

    assign busy = (state != IDLE);

    // Each state's actions take effect on the edge that leaves it, so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            watchdog   <= '0;
            grant      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_start <= 1'b0;
            mult_clr   <= 1'b0;
        end else begin
            grant     <= '0;
            rsp_valid <= 1'b0;
            mult_clr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        mult_a  <= sel_a;
                        mult_b  <= sel_b;
                        grant   <= arb_grant;
                        owner   <= arb_idx;
                        rr_ptr  <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        rsp_err <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start <= 1'b1;
                    watchdog   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the watchdog's last cycle still counts as success.
                    if (mult_done) begin
                        rsp_data   <= mult_z;
                        mult_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= owner;
                        state      <= RESP;
                    end else if (watchdog == WDW'(TIMEOUT_CYC - 1)) begin
                        mult_start <= 1'b0;
                        mult_clr   <= 1'b1;
                        state      <= ABORT;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ABORT: begin
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_id    <= owner;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
